pb_mem_console: RTL and testbench

- Parametrised successor to the board-level pushbutton/seven-segment wrapper around `system`.
- Turns raw pushbuttons into debounced, edge-triggered hex entry and memory commands. Drives handshaked read/write requests and the run/debug control into `system_if`.
- Shows entered or read-back values on a configurable number of seven-segment digits, with status LEDs.
- Sits between the board I/O pins and `system`/`system_if`.

---
 rtl/pb_mem_console_pkg.sv | 29 ++
 rtl/pb_mem_console_if.sv | 24 ++
 rtl/pb_mem_console_debounce.sv | 44 ++++
 rtl/pb_mem_console.sv | 190 +++++++++++++++++++
 tb/tb_pb_mem_console.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pb_mem_console_pkg.sv
// Shared types and constants for the pushbutton memory console.
package console_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_ERROR = 2'd3
   } state_e;

   typedef enum logic {
      SHOW_ENTRY = 1'b0,
      SHOW_READ  = 1'b1
   } show_e;

   localparam int NUM_KEYS = 21;
   localparam int KEY_CLR  = 16;
   localparam int KEY_SETA = 17;
   localparam int KEY_WR   = 18;
   localparam int KEY_RD   = 19;
   localparam int KEY_RUN  = 20;

   // Hex glyphs, active-high {dp,g,f,e,d,c,b,a}; index 0 is the rightmost entry.
   localparam logic [15:0][7:0] SEG_TBL = {
      8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
      8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
   };

endpackage

// File: rtl/pb_mem_console_if.sv
// Memory request bus and run/debug control between the console and the system.
interface pb_mem_console_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wen;
   logic              mem_ren;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              halt;
   logic              tb_ctrl;

   modport master (
      output mem_addr, mem_wdata, mem_wen, mem_ren, tb_ctrl,
      input  mem_rdata, mem_ready, halt
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_wen, mem_ren, tb_ctrl,
      output mem_rdata, mem_ready, halt
   );
endinterface

// File: rtl/pb_mem_console_debounce.sv
// One pushbutton: 2-flop synchroniser, stability debouncer, rising-edge pulse.
module pb_debounce #(
   parameter int DEBOUNCE_CYCLES = 120000
) (
   input  logic CLK,
   input  logic nRST,
   input  logic raw,
   output logic level,
   output logic rise
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          s1_q, s2_q, level_q, rise_q;
   logic [CW-1:0] cnt_q;

   // Synchronise, count consecutive disagreeing cycles, flip level when the count completes.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         s1_q   <= raw;
         s2_q   <= s1_q;
         rise_q <= 1'b0;
         if (s2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
               level_q <= s2_q;
               rise_q  <= s2_q;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
endmodule

// File: rtl/pb_mem_console.sv
// Pushbutton hex entry and memory command console with seven-segment readout.
module pb_mem_console
   import console_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int NUM_DIGITS      = 8,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int TIMEOUT_CYCLES  = 1024,
   parameter int AUTO_INC        = 1
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic [NUM_KEYS-1:0]     pb,
   pb_mem_console_if.master        bus,
   output logic [8*NUM_DIGITS-1:0] ss,
   output logic                    red,
   output logic                    green,
   output logic                    blue
);
   localparam int WC = $clog2(TIMEOUT_CYCLES + 1);

   logic [NUM_KEYS-1:0] lvl, rise;
   logic                unused_lvl;

   state_e            state_q, state_d;
   logic [WC-1:0]     wait_q, wait_d;
   logic [DATA_W-1:0] entry_q, entry_d, disp_q, disp_d, wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   show_e             show_q, show_d;
   logic              tb_q, tb_d, green_q;
   logic [NUM_DIGITS-1:0][7:0] seg_d;
   logic [8*NUM_DIGITS-1:0]    ss_q;
   logic [DATA_W-1:0] disp_val;

   logic       key_vld;
   logic [4:0] key_idx;
   logic       k_hex, k_clr, k_seta, k_wr, k_rd, k_run, done;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .CLK   (CLK),
         .nRST  (nRST),
         .raw   (pb[g]),
         .level (lvl[g]),
         .rise  (rise[g])
      );
   end

   assign unused_lvl = &{1'b0, lvl};

   // Lowest-index pulse wins; everything else in that cycle is dropped.
   always_comb begin
      key_vld = 1'b0;
      key_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (rise[i]) begin
            key_vld = 1'b1;
            key_idx = 5'(i);
         end
      end
   end

   assign k_hex  = key_vld && (key_idx < 5'd16);
   assign k_clr  = key_vld && (key_idx == 5'(KEY_CLR));
   assign k_seta = key_vld && (key_idx == 5'(KEY_SETA));
   assign k_wr   = key_vld && (key_idx == 5'(KEY_WR));
   assign k_rd   = key_vld && (key_idx == 5'(KEY_RD));
   assign k_run  = key_vld && (key_idx == 5'(KEY_RUN));
   assign done   = ((state_q == ST_WRITE) || (state_q == ST_READ)) && bus.mem_ready;

   // State register and wait counter.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         state_q <= ST_IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next state: accept commands in IDLE, wait for ready or time out, hold ERROR until CLR.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         ST_IDLE: begin
            wait_d = '0;
            if (k_wr && !tb_q)      state_d = ST_WRITE;
            else if (k_rd && !tb_q) state_d = ST_READ;
         end
         ST_WRITE, ST_READ: begin
            if (bus.mem_ready) begin
               state_d = ST_IDLE;
               wait_d  = '0;
            end else if (wait_q == WC'(TIMEOUT_CYCLES - 1)) begin
               state_d = ST_ERROR;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_ERROR: begin
            if (k_clr) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from the current state: requests are levels held for the whole wait.
   always_comb begin
      bus.mem_wen = (state_q == ST_WRITE);
      bus.mem_ren = (state_q == ST_READ);
      blue        = (state_q == ST_WRITE) || (state_q == ST_READ);
      red         = (state_q == ST_ERROR);
   end

   // Console registers: entry shift, address load/increment, read-back capture, run toggle.
   always_comb begin
      entry_d = entry_q;
      addr_d  = addr_q;
      disp_d  = disp_q;
      show_d  = show_q;
      tb_d    = tb_q;
      wdata_d = wdata_q;
      if (k_hex) begin
         entry_d = {entry_q[DATA_W-5:0], key_idx[3:0]};
         show_d  = SHOW_ENTRY;
      end
      if (k_clr) begin
         entry_d = '0;
         show_d  = SHOW_ENTRY;
      end
      if (state_q == ST_IDLE) begin
         if (k_seta) begin
            addr_d  = ADDR_W'(entry_q);
            entry_d = '0;
         end
         if (k_run)          tb_d    = ~tb_q;
         if (k_wr && !tb_q)  wdata_d = entry_q;
      end
      if (done) begin
         if (AUTO_INC != 0) addr_d = addr_q + ADDR_W'(4);
         if (state_q == ST_READ) begin
            disp_d = bus.mem_rdata;
            show_d = SHOW_READ;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (nRST) begin
         entry_q <= '0;
         addr_q  <= '0;
         disp_q  <= '0;
         show_q  <= SHOW_ENTRY;
         tb_q    <= 1'b0;
         wdata_q <= '0;
         green_q <= 1'b0;
         ss_q    <= '0;
      end else begin
         entry_q <= entry_d;
         addr_q  <= addr_d;
         disp_q  <= disp_d;
         show_q  <= show_d;
         tb_q    <= tb_d;
         wdata_q <= wdata_d;
         green_q <= bus.halt;
         ss_q    <= seg_d;
      end
   end

   // Display source mux, then one hex glyph per nibble; digits past the data width stay dark.
   always_comb disp_val = (show_q == SHOW_READ) ? disp_q : entry_q;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      if (4 * i < DATA_W) begin : g_on
         assign seg_d[i] = SEG_TBL[disp_val[4*i +: 4]];
      end else begin : g_off
         assign seg_d[i] = 8'h00;
      end
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.tb_ctrl   = tb_q;
   assign green         = green_q;
   assign ss            = ss_q;
endmodule

// File: tb/tb_pb_mem_console.sv
module tb_pb_mem_console;
   localparam int K_CLR = 16, K_SETA = 17, K_WR = 18, K_RD = 19, K_RUN = 20;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [20:0] pb;
   logic [63:0] ss;
   logic        red, green, blue;

   pb_mem_console_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   pb_mem_console #(
      .ADDR_W(32), .DATA_W(32), .NUM_DIGITS(8),
      .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(16), .AUTO_INC(1)
   ) dut (
      .CLK(CLK), .nRST(nRST), .pb(pb), .bus(bus),
      .ss(ss), .red(red), .green(green), .blue(blue)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0, n_pass = 0;

   // memory responder state
   int          rdelay = 1;
   logic [31:0] rdval  = '0;
   int          hi_cnt = 0, n_start = 0, last_cycles = 0, blue_bad = 0;
   logic [31:0] last_addr, last_wdata;
   logic        last_wr;

   // reference model of the console
   logic [31:0] m_entry, m_addr, m_disp;
   bit          m_show, m_tb, m_err;

   function automatic logic [7:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 8'h3F; 4'h1: return 8'h06; 4'h2: return 8'h5B; 4'h3: return 8'h4F;
         4'h4: return 8'h66; 4'h5: return 8'h6D; 4'h6: return 8'h7D; 4'h7: return 8'h07;
         4'h8: return 8'h7F; 4'h9: return 8'h6F; 4'hA: return 8'h77; 4'hB: return 8'h7C;
         4'hC: return 8'h39; 4'hD: return 8'h5E; 4'hE: return 8'h79; default: return 8'h71;
      endcase
   endfunction

   function automatic logic [63:0] exp_ss(input logic [31:0] v);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = glyph(v[4*i +: 4]);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic press(input int k);
      pb[k] = 1'b1;
      step(10);
      pb[k] = 1'b0;
      step(12);
   endtask

   task automatic model_key(input int k);
      if (k < 16) begin
         m_entry = {m_entry[27:0], 4'(k)};
         m_show  = 1'b0;
      end else if (k == K_CLR) begin
         m_entry = '0; m_show = 1'b0; m_err = 1'b0;
      end else if (k == K_SETA && !m_err) begin
         m_addr = m_entry; m_entry = '0;
      end else if (k == K_RUN && !m_err) begin
         m_tb = ~m_tb;
      end
   endtask

   task automatic key(input int k);
      press(k);
      model_key(k);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_ss"},   ss, exp_ss(m_show ? m_disp : m_entry));
      chk({tag, "_addr"}, bus.mem_addr, m_addr);
      chk({tag, "_tb"},   bus.tb_ctrl, m_tb);
      chk({tag, "_red"},  red, m_err);
      chk({tag, "_req"},  {bus.mem_wen, bus.mem_ren}, 2'b00);
   endtask

   task automatic do_op(input bit wr, input int dly, input logic [31:0] rv);
      int s;
      s = n_start; rdelay = dly; rdval = rv;
      press(wr ? K_WR : K_RD);
      if (dly == 0) step(20);
      if (!m_err && !m_tb) begin
         chk("txn_start",  n_start, s + 1);
         chk("txn_kind",   last_wr, wr);
         chk("txn_addr",   last_addr, m_addr);
         if (wr) chk("txn_wdata", last_wdata, m_entry);
         chk("txn_cycles", last_cycles, (dly == 0) ? 16 : dly);
         if (dly == 0) m_err = 1'b1;
         else begin
            m_addr = m_addr + 32'd4;
            if (!wr) begin m_disp = rv; m_show = 1'b1; end
         end
      end else begin
         chk("txn_ignored", n_start, s);
      end
      check_state(wr ? "wr" : "rd");
   endtask

   // Memory side: count request cycles, log each request, raise ready on the chosen cycle.
   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge CLK);
         bus.mem_ready = 1'b0;
         if (blue !== (bus.mem_wen | bus.mem_ren)) blue_bad++;
         if (bus.mem_wen | bus.mem_ren) begin
            if (hi_cnt == 0) begin
               n_start++;
               last_addr  = bus.mem_addr;
               last_wdata = bus.mem_wdata;
               last_wr    = bus.mem_wen;
            end
            hi_cnt++;
            last_cycles = hi_cnt;
            if (rdelay > 0 && hi_cnt == rdelay) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = rdval;
            end
         end else begin
            hi_cnt = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      int s, nd;
      nRST = 1'b1; pb = '0; bus.halt = 1'b0;
      m_entry = '0; m_addr = '0; m_disp = '0; m_show = 0; m_tb = 0; m_err = 0;
      step(3);
      chk("rst_ss",  ss, 64'h0);
      chk("rst_req", {bus.mem_wen, bus.mem_ren, bus.tb_ctrl, red, blue}, 5'b0);
      chk("rst_addr", bus.mem_addr, 32'h0);
      nRST = 1'b0;
      step(3);
      check_state("idle0");

      bus.halt = 1'b1; step(2); chk("green_on",  green, 1'b1);
      bus.halt = 1'b0; step(2); chk("green_off", green, 1'b0);

      // address entry, then a short glitch that must not register
      key(1); key(2); key(3); key(4);
      chk("entry_1234", ss, exp_ss(32'h1234));
      key(K_SETA);
      chk("seta_addr", bus.mem_addr, 32'h1234);
      check_state("seta");
      pb[5] = 1'b1; step(3); pb[5] = 1'b0; step(12);
      check_state("glitch");

      // write DEADBEEF, ready on the 3rd request cycle
      v = 32'hDEADBEEF;
      for (int i = 7; i >= 0; i--) key(int'(v[4*i +: 4]));
      do_op(1'b1, 3, '0);
      chk("wr_addr_inc", bus.mem_addr, 32'h1238);

      // read CAFEF00D, ready on the first request cycle
      do_op(1'b0, 1, 32'hCAFEF00D);
      chk("rd_dig0", ss[7:0],   8'h5E);
      chk("rd_dig7", ss[63:56], 8'h39);
      chk("blue_track", blue_bad, 0);

      // read that never completes
      do_op(1'b0, 0, '0);
      do_op(1'b1, 2, '0);
      key(K_CLR);
      check_state("clr");

      // run mode blocks memory commands; simultaneous keys keep the lowest
      key(K_RUN);
      chk("run_tb", bus.tb_ctrl, 1'b1);
      do_op(1'b1, 2, '0);
      do_op(1'b0, 2, 32'h1);
      pb[3] = 1'b1; pb[7] = 1'b1; step(10);
      pb[3] = 1'b0; pb[7] = 1'b0; step(12);
      model_key(3);
      check_state("dual");
      key(K_RUN);

      // randomized entries and commands
      for (int it = 0; it < 5; it++) begin
         nd = $urandom_range(1, 8);
         for (int j = 0; j < nd; j++) key($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) key(K_SETA);
         do_op(1'($urandom_range(0, 1)), $urandom_range(1, 6), $urandom);
      end
      chk("blue_track2", blue_bad, 0);

      // reset in the middle of a write wait
      rdelay = 0;
      pb[K_WR] = 1'b1;
      for (int i = 0; i < 40 && !bus.mem_wen; i++) step(1);
      chk("mid_wen_seen", bus.mem_wen, 1'b1);
      step(2);
      nRST = 1'b1; pb = '0;
      step(1);
      chk("mid_rst_req", {bus.mem_wen, bus.mem_ren, bus.tb_ctrl, red, blue}, 5'b0);
      chk("mid_rst_ss", ss, 64'h0);
      nRST = 1'b0;
      m_entry = '0; m_addr = '0; m_disp = '0; m_show = 0; m_tb = 0; m_err = 0;
      step(3);
      check_state("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
